memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-ported RAM between the pipeline's instruction-fetch port and its data port.
//  Sits between the datapath's cache interface (imemREN/imemaddr, dmemREN/dmemWEN/dmemaddr/dmemstore)
//  and the RAM. Grants one access at a time and latches the address/data for the full access.
//  Returns ihit/dhit as single-cycle pulses, which advance the pipeline latches.
//  Data has priority, with a bounded-starvation guarantee for fetch.
// PARAMETERS
//  MAX_DWIN  4   max consecutive data grants while a fetch is pending; the next grant goes to fetch
//  CW        3   width of starvation counter; must hold MAX_DWIN
// PORTS
//  CLK        in   1   clock; all state updates on posedge
//  nRST       in   1   asynchronous reset, ACTIVE-HIGH (1 = reset)
//  iREN       in   1   instruction fetch request
//  iaddr      in   32  fetch address (word_t)
//  dREN       in   1   data read request
//  dWEN       in   1   data write request
//  daddr      in   32  data address
//  dstore     in   32  write data
//  ihit       out  1   fetch complete; 1-cycle pulse; iload valid while high
//  dhit       out  1   data access complete; 1-cycle pulse; dload valid while high (reads)
//  iload      out  32  registered fetched word
//  dload      out  32  registered read word
//  ramREN     out  1   RAM read strobe
//  ramWEN     out  1   RAM write strobe
//  ramaddr    out  32  RAM address
//  ramstore   out  32  RAM write data
//  ramload    in   32  RAM read data; valid when ramready=1
//  ramready   in   1   RAM access done (1-cycle pulse)
//  ramerror   in   1   RAM access failed (1-cycle pulse; mutually exclusive with ramready)
// BEHAVIOUR
//  Reset (async, nRST=1): state=IDLE, starve_cnt=0, latched addr/store/kind=0.
//   Reset drives all outputs to 0 immediately, including mid-access; an aborted access is not replayed.
//  FSM states: IDLE, IACC, DACC, RESP.
//   IDLE: if (dREN|dWEN) && !(iREN && starve_cnt==MAX_DWIN) -> DACC;
//     else if iREN -> IACC; else stay.
//   On grant, latch addr (and dstore; kind = write if dWEN, else read).
//     dWEN and dREN both high: the write wins.
//   IACC/DACC: drive ramREN/ramWEN/ramaddr/ramstore from the latched values (registered, stable all access).
//     ramready -> RESP, capturing ramload into iload/dload (write: dload unchanged).
//     ramerror -> IDLE, no hit; request re-arbitrated next cycle (retry).
//   RESP: exactly one of ihit/dhit=1 for the access just served; RAM strobes 0; -> IDLE unconditionally.
//     RESP is a dead cycle so the requester can drop or change its request before re-arbitration.
//  Latency: min 3 cycles from request to hit (IDLE->ACC, ready in 1st ACC cycle, RESP). Back-to-back service every 3+ cycles.
//  Requests are level-sensitive; dropping a request mid-access does not abort it. The hit still pulses.
//  starve_cnt:
//   +1 on each DACC grant while iREN=1 (saturates at MAX_DWIN);
//   cleared on IACC grant or when iREN=0 in IDLE.
//  Request inputs are not sampled outside IDLE. Address change mid-access is ignored (latched copy used).
//  Hit, load and RAM outputs are all registered; there is no combinational in->out path.
// STRUCTURE
//  cpu_types_pkg: add arb_state_t enum {IDLE, IACC, DACC, RESP}.
//   word_t is reused from the existing package.
//  Single module, no sub-modules. FSM next-state logic in always_comb; registers in one always_ff.
// TESTING
//  1. iREN=1, iaddr=0x40, RAM ready after 2 cycles with 0xDEADBEEF
//     -> ramREN=1, ramaddr=0x40 for 2 cycles; ihit pulses 1 cycle with iload=0xDEADBEEF.
//  2. iREN=1 and dREN=1 (daddr=0x100) same cycle
//     -> data served first (ramaddr=0x100, dhit); fetch served next.
//  3. Starvation: dREN held with iREN, MAX_DWIN=4
//     -> 4 dhits, then an ihit, then data resumes; starve_cnt returns to 0.
//  4. dWEN=1, daddr=0x200, dstore=0x1234
//     -> ramWEN=1, ramstore=0x1234 until ready; dhit pulses; dload unchanged.
//  5. ramerror during IACC -> no ihit; FSM to IDLE; fetch re-issued next cycle at same address.
//  6. nRST pulsed mid-DACC
//     -> ramREN/ramWEN drop same cycle (async); no dhit; IDLE after release; counter=0.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package memory_arbiter_pkg;

  // Machine word carried on every address and data path.
  typedef logic [31:0] word_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Kind of the access currently latched.
  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the cache-side request/response signals and the RAM-side bus.
// The arbiter connects through the master modport.
// Whatever drives requests and models the RAM connects through the slave modport.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  // cache side
  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;

  // RAM side
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;
  logic  ramerror;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ihit, dhit, iload, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramready, ramerror
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, dhit, iload, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready, ramerror
  );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and data accesses.
// Data accesses win by default.
// After MAX_DWIN consecutive data grants made while a fetch waited, the fetch is served next.
// Every output is a flop, so there is no combinational path from any input to any output.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_DWIN = 4,
  parameter int CW       = 3
) (
  input  logic             CLK,
  input  logic             nRST,   // active-high asynchronous reset
  memory_arbiter_if.master bus
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DWIN);

  arb_state_t    state_q,      state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  word_t         addr_q,       addr_d;
  word_t         store_q,      store_d;
  acc_kind_t     kind_q,       kind_d;
  logic          ren_q,        ren_d;
  logic          wen_q,        wen_d;
  logic          ihit_q,       ihit_d;
  logic          dhit_q,       dhit_d;
  word_t         iload_q,      iload_d;
  word_t         dload_q,      dload_d;

  logic data_req;
  logic fetch_due;

  assign data_req  = bus.dREN | bus.dWEN;
  // A waiting fetch has seen its quota of data grants go by and must be served now.
  assign fetch_due = bus.iREN && (starve_cnt_q == MAX_CNT);

  // Next-state logic: arbitration in IDLE, access tracking in IACC/DACC, and the hit pulse in RESP.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    store_d      = store_q;
    kind_d       = kind_q;
    ren_d        = 1'b0;
    wen_d        = 1'b0;
    ihit_d       = 1'b0;
    dhit_d       = 1'b0;
    iload_d      = iload_q;
    dload_d      = dload_q;

    unique case (state_q)
      IDLE: begin
        if (data_req && !fetch_due) begin
          state_d = DACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          // A write request takes precedence over a read request raised in the same cycle.
          kind_d  = bus.dWEN ? ACC_WRITE : ACC_READ;
          ren_d   = !bus.dWEN;
          wen_d   = bus.dWEN;
          if (bus.iREN) begin
            starve_cnt_d = (starve_cnt_q == MAX_CNT) ? starve_cnt_q : starve_cnt_q + CW'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end else if (bus.iREN) begin
          state_d      = IACC;
          addr_d       = bus.iaddr;
          kind_d       = ACC_READ;
          ren_d        = 1'b1;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end

      IACC, DACC: begin
        // Keep the strobes up for the whole access; the address and store data stay latched.
        ren_d = ren_q;
        wen_d = wen_q;
        if (bus.ramready) begin
          state_d = RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = bus.ramload;
          end else begin
            dhit_d = 1'b1;
            if (kind_q == ACC_READ) begin
              dload_d = bus.ramload;
            end
          end
        end else if (bus.ramerror) begin
          // Drop the access without a hit; the still-raised request is re-arbitrated from IDLE.
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      end

      RESP: begin
        // Dead cycle while the hit is high, so the requester can drop its request first.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and every output register, cleared asynchronously so an in-flight access is abandoned.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      store_q      <= '0;
      kind_q       <= ACC_READ;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      ihit_q       <= 1'b0;
      dhit_q       <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      kind_q       <= kind_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      ihit_q       <= ihit_d;
      dhit_q       <= dhit_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter.
// The expected RAM accesses and hits are queued when a request is driven.
// A RAM model and a hit monitor pop those queues and compare them against the DUT.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_if bus ();

  memory_arbiter #(.MAX_DWIN(4), .CW(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
  } acc_t;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
  } hit_t;

  acc_t acc_q[$];
  hit_t hit_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  int          ram_lat    = 2;
  bit          err_once   = 1'b0;
  int          acc_cycles = 0;
  bit          have_cur   = 1'b0;
  acc_t        cur;
  logic [31:0] exp_dload  = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_acc(input logic wr, input logic [31:0] addr, input logic [31:0] store);
    acc_t e;
    e.wr = wr; e.addr = addr; e.store = store;
    acc_q.push_back(e);
  endtask

  task automatic push_hit(input logic is_d, input logic [31:0] load);
    hit_t e;
    e.is_d = is_d; e.load = load;
    hit_q.push_back(e);
  endtask

  // Expected data read: the queued hit carries the word and dload is expected to hold it afterwards.
  task automatic push_dread(input logic [31:0] addr);
    push_acc(1'b0, addr, 32'h0);
    exp_dload = mem_rd(addr);
    push_hit(1'b1, exp_dload);
  endtask

  task automatic push_iread(input logic [31:0] addr);
    push_acc(1'b0, addr, 32'h0);
    push_hit(1'b0, mem_rd(addr));
  endtask

  // Counts hits until the requested numbers are seen or the budget runs out.
  // Returns on the negedge of the last hit, which falls in the RESP dead cycle.
  task automatic wait_hits(input int ni, input int nd, input int budget, output int cyc);
    int seen_i = 0;
    int seen_d = 0;
    cyc = 0;
    while ((seen_i < ni || seen_d < nd) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (bus.ihit) seen_i++;
      if (bus.dhit) seen_d++;
    end
    check_eq("hits_in_budget", 32'(seen_i >= ni && seen_d >= nd), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // RAM model: checks each access against the queue and responds after ram_lat strobe cycles.
  initial begin
    bus.ramready = 1'b0;
    bus.ramerror = 1'b0;
    bus.ramload  = 32'h0;
    forever begin
      @(negedge CLK);
      bus.ramready = 1'b0;
      bus.ramerror = 1'b0;
      if (!nRST && (bus.ramREN || bus.ramWEN)) begin
        acc_cycles++;
        if (acc_cycles == 1) begin
          check_eq("ram_access_expected", 32'(acc_q.size() != 0), 32'd1);
          if (acc_q.size() != 0) begin
            cur      = acc_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          check_eq("ramaddr", bus.ramaddr, cur.addr);
          check_eq("ramWEN", 32'(bus.ramWEN), 32'(cur.wr));
          check_eq("ramREN", 32'(bus.ramREN), 32'(!cur.wr));
          if (cur.wr) check_eq("ramstore", bus.ramstore, cur.store);
        end
        if (acc_cycles >= ram_lat) begin
          if (err_once) begin
            bus.ramerror = 1'b1;
            err_once     = 1'b0;
            $display("ram  error addr=%h", bus.ramaddr);
          end else begin
            bus.ramready = 1'b1;
            if (bus.ramWEN) begin
              mem[bus.ramaddr] = bus.ramstore;
              bus.ramload      = 32'hBAD0_BAD0;
              $display("ram  write addr=%h data=%h", bus.ramaddr, bus.ramstore);
            end else begin
              bus.ramload = mem_rd(bus.ramaddr);
              $display("ram  read  addr=%h data=%h", bus.ramaddr, bus.ramload);
            end
          end
          acc_cycles = 0;
          have_cur   = 1'b0;
        end
      end else begin
        acc_cycles = 0;
        have_cur   = 1'b0;
      end
    end
  end

  // Hit monitor: every hit must match the next queued expectation.
  initial begin
    hit_t e;
    forever begin
      @(negedge CLK);
      if (bus.ihit || bus.dhit) begin
        check_eq("single_hit", 32'(bus.ihit & bus.dhit), 32'd0);
        check_eq("hit_expected", 32'(hit_q.size() != 0), 32'd1);
        if (hit_q.size() != 0) begin
          e = hit_q.pop_front();
          check_eq("hit_kind_is_d", 32'(bus.dhit), 32'(e.is_d));
          if (e.is_d) check_eq("dload", bus.dload, e.load);
          else        check_eq("iload", bus.iload, e.load);
        end
        $display("hit  %s iload=%h dload=%h", bus.dhit ? "data " : "fetch", bus.iload, bus.dload);
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    bus.iREN   = 1'b0;
    bus.iaddr  = 32'h0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = 32'h0;
    bus.dstore = 32'h0;
    mem[32'h40] = 32'hDEADBEEF;
    nRST = 1'b1;
    idle_cycles(3);

    // reset state
    check_eq("rst_ihit",     32'(bus.ihit),   32'd0);
    check_eq("rst_dhit",     32'(bus.dhit),   32'd0);
    check_eq("rst_ramREN",   32'(bus.ramREN), 32'd0);
    check_eq("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    check_eq("rst_ramaddr",  bus.ramaddr,     32'h0);
    check_eq("rst_ramstore", bus.ramstore,    32'h0);
    check_eq("rst_iload",    bus.iload,       32'h0);
    check_eq("rst_dload",    bus.dload,       32'h0);
    nRST = 1'b0;
    idle_cycles(2);

    // single fetch, RAM answers in the second access cycle
    ram_lat = 2;
    push_iread(32'h40);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    wait_hits(1, 0, 20, cyc);
    bus.iREN = 1'b0;
    check_eq("t1_latency", 32'(cyc), 32'd3);
    idle_cycles(2);

    // minimum latency fetch
    ram_lat = 1;
    push_iread(32'h44);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    wait_hits(1, 0, 20, cyc);
    bus.iREN = 1'b0;
    check_eq("min_latency", 32'(cyc), 32'd2);
    idle_cycles(2);

    // simultaneous requests: data first, then fetch
    push_dread(32'h100);
    push_iread(32'h80);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h80;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    wait_hits(0, 1, 20, cyc);
    bus.dREN = 1'b0;
    wait_hits(1, 0, 20, cyc);
    bus.iREN = 1'b0;
    idle_cycles(2);

    // starvation bound: four data grants, one fetch, then data again
    for (int i = 0; i < 4; i++) push_dread(32'h104);
    push_iread(32'h84);
    push_dread(32'h104);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h84;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h104;
    wait_hits(1, 4, 60, cyc);
    bus.iREN = 1'b0;
    check_eq("t3_starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
    wait_hits(0, 1, 20, cyc);
    bus.dREN = 1'b0;
    idle_cycles(2);

    // write: strobes and store data held until ready, dload keeps the last read word
    ram_lat = 2;
    push_acc(1'b1, 32'h200, 32'h1234);
    push_hit(1'b1, exp_dload);
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h200;
    bus.dstore = 32'h1234;
    wait_hits(0, 1, 20, cyc);
    bus.dWEN = 1'b0;
    idle_cycles(2);

    // read and write raised together: the write is performed
    push_acc(1'b1, 32'h204, 32'h5678);
    push_hit(1'b1, exp_dload);
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h204;
    bus.dstore = 32'h5678;
    wait_hits(0, 1, 20, cyc);
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    idle_cycles(2);

    // read back the first written word
    push_acc(1'b0, 32'h200, 32'h0);
    exp_dload = 32'h1234;
    push_hit(1'b1, 32'h1234);
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    wait_hits(0, 1, 20, cyc);
    bus.dREN = 1'b0;
    idle_cycles(2);

    // RAM error during a fetch: no hit, retried from IDLE at the same address
    err_once = 1'b1;
    push_acc(1'b0, 32'h300, 32'h0);
    push_iread(32'h300);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h300;
    wait_hits(1, 0, 30, cyc);
    bus.iREN = 1'b0;
    check_eq("t5_retry_latency", 32'(cyc), 32'd6);
    idle_cycles(2);

    // reset asserted in the middle of a data access
    ram_lat = 5;
    push_acc(1'b0, 32'h400, 32'h0);
    bus.dREN  = 1'b1;
    bus.daddr = 32'h400;
    n = 0;
    while (!bus.ramREN && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check_eq("t6_access_started", 32'(bus.ramREN), 32'd1);
    @(negedge CLK);
    bus.dREN = 1'b0;
    nRST     = 1'b1;
    #1;
    check_eq("t6_ramREN_async", 32'(bus.ramREN), 32'd0);
    check_eq("t6_ramWEN_async", 32'(bus.ramWEN), 32'd0);
    check_eq("t6_dhit",         32'(bus.dhit),   32'd0);
    check_eq("t6_dload_cleared", bus.dload,      32'h0);
    check_eq("t6_iload_cleared", bus.iload,      32'h0);
    idle_cycles(2);
    nRST = 1'b0;
    idle_cycles(3);
    check_eq("t6_state_idle",  32'(dut.state_q),      32'(IDLE));
    check_eq("t6_starve_cnt",  32'(dut.starve_cnt_q), 32'd0);
    check_eq("t6_ramREN_idle", 32'(bus.ramREN),       32'd0);

    // every queued expectation must have been consumed
    check_eq("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    check_eq("hit_queue_empty", 32'(hit_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
